// File: rtl/uart_program_loader_if.sv
// rtl/uart_program_loader_if.sv - UART receive, transmit-request and imem write signals of the program loader
interface uart_program_loader_if #(
  parameter int IMEM_SIZE = 14
);
  logic                 enable;
  logic                 rx_ready;
  logic [7:0]           rdata;
  logic                 tx_busy;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 imem_we;
  logic [IMEM_SIZE-1:0] imem_addr;
  logic [31:0]          imem_wdata;
  logic [31:0]          words_loaded;
  logic                 done;
  logic                 overflow;

  modport master (
    output enable, rx_ready, rdata, tx_busy,
    input  tx_start, tx_data, imem_we, imem_addr, imem_wdata, words_loaded, done, overflow
  );

  modport slave (
    input  enable, rx_ready, rdata, tx_busy,
    output tx_start, tx_data, imem_we, imem_addr, imem_wdata, words_loaded, done, overflow
  );
endinterface

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - receives a length-prefixed big-endian word image over UART and writes it to imem
module uart_program_loader #(
  parameter int         IMEM_SIZE = 14,
  parameter logic [7:0] ACK_BYTE  = 8'hAA
) (
  input  logic                  clk,
  input  logic                  rstn,
  uart_program_loader_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_ACK, S_FIN} state_t;

  localparam logic [31:0] DEPTH = 32'(1) << IMEM_SIZE;

  state_t               state_q;
  logic [1:0]           idx_q;
  logic [31:0]          len_q;
  logic [23:0]          asm_q;
  logic                 tx_start_q;
  logic [7:0]           tx_data_q;
  logic                 imem_we_q;
  logic [IMEM_SIZE-1:0] imem_addr_q;
  logic [31:0]          imem_wdata_q;
  logic [31:0]          words_q;
  logic                 done_q;
  logic                 overflow_q;

  logic [31:0] len_d;
  logic [31:0] word_d;
  logic [31:0] words_d;

  assign len_d   = {len_q[23:0], bus.rdata};
  assign word_d  = {asm_q, bus.rdata};
  assign words_d = words_q + 32'd1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      len_q        <= 32'd0;
      asm_q        <= 24'd0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= ACK_BYTE;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      words_q      <= 32'd0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      imem_we_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.enable) begin
            state_q <= S_LEN;
            idx_q   <= 2'd0;
            len_q   <= 32'd0;
            words_q <= 32'd0;
          end
        end
        S_LEN: begin
          if (!bus.enable) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
          end else if (bus.rx_ready) begin
            len_q <= len_d;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              if (len_d > DEPTH) overflow_q <= 1'b1;
              state_q <= (len_d == 32'd0) ? S_ACK : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (!bus.enable) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
          end else if (bus.rx_ready) begin
            asm_q <= word_d[23:0];
            idx_q <= idx_q + 2'd1;
            // Write registers are separate from asm_q, so the next byte can land in the same cycle
            if (idx_q == 2'd3) begin
              imem_we_q    <= (words_q < DEPTH);
              imem_addr_q  <= words_q[IMEM_SIZE-1:0];
              imem_wdata_q <= word_d;
              words_q      <= words_d;
              if (words_d == len_q) state_q <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (!bus.tx_busy && !tx_start_q) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= ACK_BYTE;
            done_q     <= 1'b1;
            state_q    <= S_FIN;
          end
        end
        S_FIN: begin
          done_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_start     = tx_start_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.imem_we      = imem_we_q;
  assign bus.imem_addr    = imem_addr_q;
  assign bus.imem_wdata   = imem_wdata_q;
  assign bus.words_loaded = words_q;
  assign bus.done         = done_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - randomized scoreboard bench for uart_program_loader
module tb_uart_program_loader;
  localparam int IMEM_SIZE = 2;
  localparam int DEPTH     = 1 << IMEM_SIZE;

  logic clk;
  logic rstn;

  uart_program_loader_if #(.IMEM_SIZE(IMEM_SIZE)) bus ();

  uart_program_loader #(.IMEM_SIZE(IMEM_SIZE), .ACK_BYTE(8'hAA)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] words_a [0:15];
  int          n_pass = 0;
  int          n_total = 0;
  logic        prev_tx_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Scoreboard monitor: every DUT write or transmit request must match the head of its queue
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (bus.imem_we === 1'b1) begin
        if (exp_wr.size() == 0) chk("unexpected_imem_we", {31'd0, bus.imem_we}, 32'd0);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("imem_addr", 32'(bus.imem_addr), e.addr);
          chk("imem_wdata", bus.imem_wdata, e.data);
        end
      end
      if (bus.tx_start === 1'b1) begin
        chk("tx_start_not_consecutive", {31'd0, prev_tx_start}, 32'd0);
        if (exp_tx.size() == 0) chk("unexpected_tx_start", {31'd0, bus.tx_start}, 32'd0);
        else chk("tx_data", {24'd0, bus.tx_data}, {24'd0, exp_tx.pop_front()});
      end
    end
    prev_tx_start = bus.tx_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn         = 1'b0;
    bus.enable   = 1'b0;
    bus.rx_ready = 1'b0;
    bus.rdata    = 8'h00;
    bus.tx_busy  = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic check_reset_state();
    chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'h0000_00AA);
    chk("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_imem_wdata", bus.imem_wdata, 32'd0);
    chk("rst_words_loaded", bus.words_loaded, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_ready = 1'b1;
    bus.rdata    = b;
    tick();
    bus.rx_ready = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 3; k >= 0; k--) send_byte(8'((w >> (8 * k)) & 32'hFF), int'($urandom_range(0, maxgap)));
  endtask

  // Reference: word i lands at address i only while i fits the memory; one ACK follows
  task automatic start_load(input int n, input int maxgap, input int send_n);
    for (int i = 0; i < n; i++)
      if (i < DEPTH) exp_wr.push_back('{addr: 32'(i), data: words_a[i]});
    exp_tx.push_back(8'hAA);
    bus.enable = 1'b1;
    tick();
    send_word(32'(n), maxgap);
    for (int i = 0; i < send_n; i++) send_word(words_a[i], maxgap);
  endtask

  task automatic finish_load(input int n);
    int budget;
    budget = 0;
    while (bus.done !== 1'b1 && budget < 300) begin
      tick();
      budget++;
    end
    tick();
    chk("done", {31'd0, bus.done}, 32'd1);
    chk("overflow", {31'd0, bus.overflow}, {31'd0, n > DEPTH});
    chk("words_loaded", bus.words_loaded, 32'(n));
    chk("writes_outstanding", 32'(exp_wr.size()), 32'd0);
    chk("acks_outstanding", 32'(exp_tx.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic busy_seen;

    do_reset();
    check_reset_state();

    words_a[0] = 32'hDEADBEEF;
    words_a[1] = 32'h01234567;
    start_load(2, 0, 2);
    finish_load(2);

    do_reset();
    check_reset_state();
    start_load(0, 1, 0);
    finish_load(0);

    do_reset();
    words_a[0] = $urandom;
    bus.tx_busy = 1'b1;
    start_load(1, 0, 1);
    busy_seen = 1'b0;
    repeat (50) begin
      if (bus.tx_start !== 1'b0) busy_seen = 1'b1;
      tick();
    end
    chk("tx_start_while_busy", {31'd0, busy_seen}, 32'd0);
    bus.tx_busy = 1'b0;
    tick();
    chk("tx_start_first_free_cycle", {31'd0, bus.tx_start}, 32'd1);
    finish_load(1);

    do_reset();
    for (int i = 0; i < 5; i++) words_a[i] = 32'(i + 1);
    start_load(5, 1, 5);
    finish_load(5);

    do_reset();
    bus.enable = 1'b1;
    tick();
    send_word(32'd1, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset();
    words_a[0] = 32'hCAFEF00D;
    start_load(1, 0, 1);
    finish_load(1);

    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), int'($urandom_range(0, 1)));
    chk("gated_words_loaded", bus.words_loaded, 32'd0);
    words_a[0] = $urandom;
    words_a[1] = $urandom;
    start_load(2, 0, 2);
    finish_load(2);
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    chk("done_sticky", {31'd0, bus.done}, 32'd1);
    chk("fin_words_loaded", bus.words_loaded, 32'd2);

    for (int t = 0; t < 10; t++) begin
      do_reset();
      n = int'($urandom_range(0, 6));
      for (int i = 0; i < n; i++) words_a[i] = $urandom;
      bus.tx_busy = 1'($urandom_range(0, 1));
      start_load(n, 2, n);
      repeat ($urandom_range(0, 5)) tick();
      bus.tx_busy = 1'b0;
      finish_load(n);
    end

    chk("final_writes_outstanding", 32'(exp_wr.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Receive-side counterpart of the load-mode handshake: after the core emits the 0xAA sync byte, this block receives the program image from the host over the UART byte stream.
- Assembles bytes into 32-bit instruction words and writes them sequentially into instruction memory.
- On completion, returns a 0xAA acknowledge byte to the host and raises done, so the top level can switch mode from LOAD to EXEC.

Parameters:
- IMEM_SIZE, 14, log2 of instruction memory depth in words.
- ACK_BYTE, 8'hAA, byte sent to the host after the last word is written.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous reset, active low
- enable  in  1  level; high when load mode is active and the sync byte has been sent
- rx_ready  in  1  one-cycle strobe from uart_rx; rdata is valid this cycle
- rdata  in  8  received byte
- tx_busy  in  1  uart_tx busy
- tx_start  out  1  one-cycle transmit request
- tx_data  out  8  byte to transmit; held stable while tx_start is high
- imem_we  out  1  one-cycle instruction memory write strobe
- imem_addr  out  IMEM_SIZE  word address
- imem_wdata  out  32  instruction word
- words_loaded  out  32  count of words received so far
- done  out  1  sticky; load complete
- overflow  out  1  sticky; header word count exceeded 2**IMEM_SIZE

Behaviour:
- Protocol: 4-byte word count N, big-endian, then N words of 4 bytes each, big-endian (first byte → bits [31:24]).
- Reset (rstn=0 at posedge): state goes to IDLE. tx_start, imem_we, done and overflow are 0. imem_addr, imem_wdata and words_loaded are 0. tx_data resets to ACK_BYTE. The byte index and N are cleared. Reset mid-transfer abandons it; no further writes occur.
- States: IDLE, LEN, DATA, ACK, FIN.
- IDLE:
  - enable=1 → LEN next cycle.
  - rx_ready strobes while in IDLE are ignored; the byte is lost.
- LEN:
  - Each rx_ready shifts rdata into N (N <= {N[23:0], rdata}) and increments the byte index.
  - On the 4th byte: byte index returns to 0, and overflow is set if the final N > 2**IMEM_SIZE.
  - Final N==0 → ACK. Otherwise → DATA.
- DATA:
  - Each rx_ready shifts rdata into a 32-bit assembly register.
  - On the 4th byte, in the following cycle: imem_we=1 for exactly one cycle, imem_wdata=assembled word, imem_addr=words_loaded[IMEM_SIZE-1:0], and words_loaded increments.
  - Words with index ≥ 2**IMEM_SIZE are consumed and counted, but imem_we stays 0, so no wrap-around overwrite occurs.
  - When words_loaded reaches N after the increment → ACK.
- ACK:
  - On the first cycle with tx_busy=0: tx_start=1 for one cycle with tx_data=ACK_BYTE, then → FIN.
  - tx_start is never asserted in two consecutive cycles.
- FIN:
  - done=1 from the first FIN cycle; sticky until reset.
  - All further rx_ready strobes are ignored.
  - enable falling has no effect on done.
- enable dropping in LEN or DATA: return to IDLE next cycle. Partial word and byte index are discarded. words_loaded and N are kept until the next entry to LEN, which clears them.
- An rx_ready arriving in the same cycle as the 4th-byte-triggered write: accepted as byte 0 of the next word. The write path uses its own registers, so no byte is dropped.
- Back-to-back rx_ready on consecutive cycles: must be supported.
- Arithmetic:
  - words_loaded is a 32-bit unsigned counter.
  - The N comparison is 32-bit unsigned.
  - The byte index is 2 bits and wraps 3→0.

Test Plan:
- Load 2 words. Reset, enable=1, send 00 00 00 02, DE AD BE EF, 01 23 45 67 → two imem_we pulses: addr0=DEADBEEF, addr1=01234567. Then one tx_start with tx_data=AA, done=1, words_loaded=2, overflow=0.
- Zero length. Send 00 00 00 00 → no imem_we; tx_start with AA issued; done=1.
- ACK back-pressure. tx_busy=1 held for 50 cycles after the last byte of a 1-word load → tx_start stays 0 throughout, then pulses exactly once, on the first cycle tx_busy=0.
- Overflow. IMEM_SIZE=2, N=5, send words 1..5 → writes at addr 0..3 only; 5th word not written; overflow=1, words_loaded=5, done=1.
- Abort. Assert rstn=0 after 2 data bytes of word 0, then release and reload N=1 with word CAFEF00D → single write addr0=CAFEF00D; no stale partial write.
- Gating and back-to-back. Send rx_ready strobes while enable=0 → ignored. Then deliver 12 bytes (N=2) on consecutive-cycle strobes → both words written correctly.
